// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter sharing one FIFO write port between two producers:
// round-robin with bounded bursts, occupancy-gated grants, registered write.
//
// state  | meaning
// IDLE   | no burst owner; ties go to the producer that did not win last
// BURST0 | producer 0 owns the port until it drops, stalls out or hits MAX_BURST
// BURST1 | producer 1 owns the port, same rules mirrored
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  gnt1,
    input  logic [CNT_WIDTH-1:0]  data_count,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [7:0]            stall_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]      MAX_B   = BW'(MAX_BURST);
    localparam logic [BW-1:0]      ONE_B   = BW'(1);
    localparam logic [CNT_WIDTH:0] DEPTH_C = (CNT_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BURST0, BURST1} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  last_q, last_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]            stall_q, stall_d;

    logic                  g0, g1;
    logic [CNT_WIDTH:0]    fill;
    logic                  space;

    // The registered write is still in flight, so it counts against free space.
    assign fill  = {1'b0, data_count} + {{CNT_WIDTH{1'b0}}, wr_en_q};
    assign space = fill < DEPTH_C;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        g0      = 1'b0;
        g1      = 1'b0;
        case (state_q)
            IDLE: begin
                if (space) begin
                    if (req0 && (!req1 || last_q)) begin
                        g0      = 1'b1;
                        state_d = BURST0;
                        beat_d  = ONE_B;
                        last_d  = 1'b0;
                    end else if (req1) begin
                        g1      = 1'b1;
                        state_d = BURST1;
                        beat_d  = ONE_B;
                        last_d  = 1'b1;
                    end
                end
            end
            BURST0: begin
                if (space) begin
                    if (req0 && (beat_q < MAX_B || !req1)) begin
                        g0 = 1'b1;
                        if (beat_q < MAX_B) beat_d = beat_q + ONE_B;
                    end else if (req1) begin
                        g1      = 1'b1;
                        state_d = BURST1;
                        beat_d  = ONE_B;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end
                end
            end
            BURST1: begin
                if (space) begin
                    if (req1 && (beat_q < MAX_B || !req0)) begin
                        g1 = 1'b1;
                        if (beat_q < MAX_B) beat_d = beat_q + ONE_B;
                    end else if (req0) begin
                        g0      = 1'b1;
                        state_d = BURST0;
                        beat_d  = ONE_B;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Grants are forced low for the whole time reset is asserted.
    assign gnt0 = g0 & reset_n;
    assign gnt1 = g1 & reset_n;

    always_comb begin
        wr_en_d   = gnt0 | gnt1;
        wr_data_d = wr_data_q;
        if (gnt0)      wr_data_d = din0;
        else if (gnt1) wr_data_d = din1;
        stall_d = stall_q;
        if ((req0 || req1) && !space && stall_q != 8'hFF) stall_d = stall_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            last_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            stall_q   <= stall_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: hand-computed grant, write and stall
// expectations over streaming, tie, full, handoff, saturation and reset cases.
module tb_fifo_wr_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0, req1;
    logic [7:0] din0, din1;
    logic       gnt0, gnt1;
    logic [3:0] dc;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] stall_cnt;

    int vectors;
    int miscompares;
    int pulses;
    int n0, n1;
    logic       e0;
    logic [7:0] edata;

    fifo_wr_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0       (req0),
        .din0       (din0),
        .gnt0       (gnt0),
        .req1       (req1),
        .din1       (din1),
        .gnt1       (gnt1),
        .data_count (dc),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        din0 = 8'h00; din1 = 8'h00;
        dc = 4'd0;
        #1 reset_n = 1'b0;

        // Reset state; requests must not leak a grant while reset is low
        req0 = 1'b1;
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_stall", stall_cnt, 0);
        tick();
        chk("rst_hold_gnt0", gnt0, 0);
        chk("rst_hold_wr_en", wr_en, 0);
        req0 = 1'b0;
        reset_n = 1'b1;
        tick();

        // Single producer streaming into an empty FIFO
        pulses = 0;
        req0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            din0 = 8'h20 + 8'(k);
            dc = (k == 0) ? 4'd0 : ((k - 1 > 8) ? 4'd8 : 4'(k - 1));
            #1;
            chk("single_gnt0", gnt0, (k < 8));
            chk("single_gnt1", gnt1, 0);
            tick();
            chk("single_wr_en", wr_en, (k < 8));
            if (k < 8) chk("single_wr_data", wr_data, 8'h20 + 8'(k));
            if (wr_en) pulses++;
        end
        chk("single_pulses", pulses, 8);
        req0 = 1'b0;
        dc = 4'd0;
        tick();

        // Tie from reset: 4 beats to producer 0, then 4 to producer 1, alternating
        do_reset();
        n0 = 0; n1 = 0;
        req0 = 1'b1; req1 = 1'b1;
        dc = 4'd0;
        for (int k = 0; k < 16; k++) begin
            din0 = 8'h40 + 8'(n0);
            din1 = 8'hA0 + 8'(n1);
            #1;
            e0 = (((k / 4) % 2) == 0);
            edata = e0 ? (8'h40 + 8'(n0)) : (8'hA0 + 8'(n1));
            chk("tie_gnt0", gnt0, e0);
            chk("tie_gnt1", gnt1, !e0);
            tick();
            chk("tie_wr_en", wr_en, 1);
            chk("tie_wr_data", wr_data, edata);
            if (e0) n0++; else n1++;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Full stall: in-flight write at DEPTH-1 blocks, then release at 6
        do_reset();
        req1 = 1'b1;
        din1 = 8'h5A;
        dc = 4'd6;
        #1;
        chk("full_first_gnt1", gnt1, 1);
        chk("full_stall0", stall_cnt, 0);
        tick();
        chk("full_inflight", wr_en, 1);
        dc = 4'd7;
        #1;
        chk("full_7_inflight_gnt1", gnt1, 0);
        tick();
        chk("full_stall1", stall_cnt, 1);
        chk("full_wr_en_off", wr_en, 0);
        dc = 4'd8;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("full_8_gnt1", gnt1, 0);
            tick();
            chk("full_stall_inc", stall_cnt, 2 + i);
        end
        dc = 4'd6;
        din1 = 8'h5B;
        #1;
        chk("full_release_gnt1", gnt1, 1);
        tick();
        chk("full_stall_hold", stall_cnt, 3);
        chk("full_release_data", wr_data, 8'h5B);
        req1 = 1'b0;
        tick();

        // Handoff when the burst owner drops mid-burst
        do_reset();
        req0 = 1'b1;
        din0 = 8'h11;
        dc = 4'd0;
        #1;
        chk("ho_beat1_gnt0", gnt0, 1);
        tick();
        #1;
        chk("ho_beat2_gnt0", gnt0, 1);
        tick();
        req0 = 1'b0;
        req1 = 1'b1;
        din1 = 8'h22;
        #1;
        chk("ho_gnt1", gnt1, 1);
        chk("ho_gnt0", gnt0, 0);
        tick();
        chk("ho_wr_data", wr_data, 8'h22);
        req1 = 1'b0;
        #1;
        chk("ho_idle_gnt1", gnt1, 0);
        tick();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("ho_tie_gnt0", gnt0, 1);
        chk("ho_tie_gnt1", gnt1, 0);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // stall_cnt saturation with a permanently full FIFO
        do_reset();
        req0 = 1'b1;
        dc = 4'd8;
        #1;
        chk("sat_gnt0_start", gnt0, 0);
        chk("sat_stall_start", stall_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 253) chk("sat_stall_254", stall_cnt, 254);
        end
        chk("sat_stall_255", stall_cnt, 255);
        chk("sat_gnt0_end", gnt0, 0);
        chk("sat_wr_en", wr_en, 0);
        req0 = 1'b0;
        dc = 4'd0;
        tick();

        // Asynchronous reset in the middle of a burst
        do_reset();
        req0 = 1'b1;
        din0 = 8'h77;
        #1;
        chk("ar_gnt0_idle", gnt0, 1);
        tick();
        chk("ar_wr_en_before", wr_en, 1);
        #1;
        chk("ar_gnt0_burst", gnt0, 1);
        reset_n = 1'b0;
        #1;
        chk("ar_wr_en_cleared", wr_en, 0);
        chk("ar_gnt0_cleared", gnt0, 0);
        chk("ar_wr_data_cleared", wr_data, 8'h00);
        req0 = 1'b0;
        req1 = 1'b1;
        din1 = 8'h99;
        #1 reset_n = 1'b1;
        #1;
        chk("ar_gnt1_after", gnt1, 1);
        tick();
        chk("ar_wr_en_after", wr_en, 1);
        chk("ar_wr_data_after", wr_data, 8'h99);
        req1 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
